// File: rtl/cursor_ctrl.sv
// cursor_ctrl: decodes UART command bytes into a frame-synchronised cursor position/colour
// and echoes each byte back through a one-entry valid/ready buffer.
// Ports: clk_i, rst_ni (async, active-low); rx_data_i/rx_valid_i received byte strobe;
//   frame_tick_i commits shadow registers; tx_ready_i/tx_data_o/tx_valid_o echo handshake;
//   cx_o/cy_o/cl_o committed cursor; pending_o shadow differs from committed;
//   drop_cnt_o saturating count of lost echoes.
// Option: define CURSOR_WRAP_EN to wrap moves at the screen edges instead of clamping.
module cursor_ctrl #(
  parameter int H_MAX  = 639,
  parameter int V_MAX  = 479,
  parameter int STEP   = 8,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       frame_tick_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic [9:0] cx_o,
  output logic [9:0] cy_o,
  output logic [1:0] cl_o,
  output logic       pending_o,
  output logic [7:0] drop_cnt_o
);
  typedef enum logic {EMPTY, FULL} state_e;
  localparam logic signed [11:0] S1 = 12'(STEP);
  localparam logic signed [11:0] S4 = 12'(4 * STEP);
  state_e state_q;
  logic [9:0] sx_q, sy_q, sx_d, sy_d, cx_q, cy_q;
  logic [1:0] scl_q, scl_d, cl_q;
  logic [7:0] tx_data_q, drop_q, echo;
  logic pending_q, known;
  logic signed [11:0] dx, dy;
  // Brings an out-of-range coordinate back onto the screen.
  function automatic logic [9:0] fit(input logic signed [11:0] v, input int max);
    logic signed [11:0] m;
    m = 12'(max);
`ifdef CURSOR_WRAP_EN
    return v < 0 ? 10'(v + m + 12'sd1) : v > m ? 10'(v - m - 12'sd1) : 10'(v);
`else
    return v < 0 ? 10'd0 : v > m ? 10'(m) : 10'(v);
`endif
  endfunction
  always_comb begin
    dx = '0;
    dy = '0;
    known = 1'b1;
    case (rx_data_i)
      "w": dy = -S1;
      "W": dy = -S4;
      "s": dy = S1;
      "S": dy = S4;
      "a": dx = -S1;
      "A": dx = -S4;
      "d": dx = S1;
      "D": dx = S4;
      "c", "r": known = 1'b1;
      default: known = 1'b0;
    endcase
    sx_d  = rx_data_i == "r" ? 10'(X_INIT) : fit($signed({2'b00, sx_q}) + dx, H_MAX);
    sy_d  = rx_data_i == "r" ? 10'(Y_INIT) : fit($signed({2'b00, sy_q}) + dy, V_MAX);
    scl_d = rx_data_i == "c" ? scl_q + 2'd1 : scl_q;
    echo  = known ? rx_data_i : 8'h3F;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q      <= 10'(X_INIT);
      sy_q      <= 10'(Y_INIT);
      scl_q     <= '0;
      cx_q      <= 10'(X_INIT);
      cy_q      <= 10'(Y_INIT);
      cl_q      <= '0;
      pending_q <= 1'b0;
      state_q   <= EMPTY;
      tx_data_q <= '0;
      drop_q    <= '0;
    end else begin
      if (rx_valid_i) begin
        sx_q  <= sx_d;
        sy_q  <= sy_d;
        scl_q <= scl_d;
      end
      // Commit samples the shadows before this cycle's command lands.
      if (frame_tick_i) begin
        cx_q <= sx_q;
        cy_q <= sy_q;
        cl_q <= scl_q;
      end
      pending_q <= {sx_q, sy_q, scl_q} != {cx_q, cy_q, cl_q};
      case (state_q)
        EMPTY: if (rx_valid_i) begin
          tx_data_q <= echo;
          state_q   <= FULL;
        end
        FULL: if (tx_ready_i) begin
          if (rx_valid_i) tx_data_q <= echo;
          else state_q <= EMPTY;
        end else if (rx_valid_i && drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
  assign tx_valid_o = state_q == FULL;
  assign tx_data_o  = tx_data_q;
  assign cx_o       = cx_q;
  assign cy_o       = cy_q;
  assign cl_o       = cl_q;
  assign pending_o  = pending_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: scoreboard bench for cursor_ctrl.
module tb_cursor_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, frame_tick = 1'b0, tx_ready = 1'b1;
  logic [7:0] tx_data, drop_cnt;
  logic tx_valid, pending;
  logic [9:0] cx, cy;
  logic [1:0] cl;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int passed = 0, total = 0;

  cursor_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .frame_tick_i(frame_tick), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .tx_valid_o(tx_valid), .cx_o(cx), .cy_o(cy), .cl_o(cl), .pending_o(pending),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // Echo checker: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && tx_valid && tx_ready) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL echo_unexpected got %h expected none", tx_data);
      else begin
        e = exp_q.pop_front();
        if (tx_data !== e) $display("FAIL echo got %h expected %h", tx_data, e);
        else passed++;
      end
    end
  end

  function automatic logic [7:0] echo_of(input logic [7:0] b);
    return (b == "w" || b == "W" || b == "s" || b == "S" || b == "a" || b == "A" ||
            b == "d" || b == "D" || b == "c" || b == "r") ? b : 8'h3F;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    frame_tick = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit echo);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    if (echo) exp_q.push_back(echo_of(b));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL %s_drain got %0d echoes outstanding expected 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({cx, cy, cl, tx_valid, pending, drop_cnt} !== {10'd320, 10'd240, 2'd0, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset got cx=%0d cy=%0d cl=%0d v=%b p=%b d=%0d expected 320 240 0 0 0 0",
               cx, cy, cl, tx_valid, pending, drop_cnt);
    else passed++;
  endtask

  task automatic test_move();
    do_reset();
    send("d", 1);
    send("d", 1);
    send("S", 1);
    total++;
    if (pending !== 1'b1 || cx !== 10'd320) $display("FAIL move_pre got p=%b cx=%0d expected 1 320", pending, cx);
    else passed++;
    tick();
    total++;
    if (cx !== 10'd336 || cy !== 10'd272) $display("FAIL move_commit got cx=%0d cy=%0d expected 336 272", cx, cy);
    else passed++;
    total++;
    if (pending !== 1'b0) $display("FAIL move_pending got %b expected 0", pending);
    else passed++;
    drain("move");
  endtask

  task automatic test_edges();
    do_reset();
    repeat (50) send("a", 1);
    tick();
    total++;
`ifdef CURSOR_WRAP_EN
    if (cx !== 10'd560) $display("FAIL left_edge got %0d expected 560", cx);
`else
    if (cx !== 10'd0) $display("FAIL left_edge got %0d expected 0", cx);
`endif
    else passed++;
    send("r", 1);
    repeat (10) send("D", 1);
    tick();
    total++;
`ifdef CURSOR_WRAP_EN
    if (cx !== 10'd0) $display("FAIL right_edge got %0d expected 0", cx);
`else
    if (cx !== 10'd639) $display("FAIL right_edge got %0d expected 639", cx);
`endif
    else passed++;
    send("r", 1);
    tick();
    total++;
    if (cx !== 10'd320 || cy !== 10'd240) $display("FAIL recentre got cx=%0d cy=%0d expected 320 240", cx, cy);
    else passed++;
    drain("edges");
  endtask

  task automatic test_colour();
    do_reset();
    repeat (5) send("c", 1);
    send(8'h7A, 1);
    tick();
    total++;
    if (cl !== 2'd1) $display("FAIL colour got %0d expected 1", cl);
    else passed++;
    total++;
    if (cx !== 10'd320 || cy !== 10'd240) $display("FAIL unknown_byte got cx=%0d cy=%0d expected 320 240", cx, cy);
    else passed++;
    drain("colour");
  endtask

  task automatic test_drop();
    do_reset();
    tx_ready = 1'b0;
    send("w", 1);
    send("w", 0);
    send("w", 0);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) $display("FAIL drop_hold got v=%b d=%h expected 1 77", tx_valid, tx_data);
    else passed++;
    total++;
    if (drop_cnt !== 8'd2) $display("FAIL drop_cnt got %0d expected 2", drop_cnt);
    else passed++;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) $display("FAIL drop_release got %b expected 0", tx_valid);
    else passed++;
    drain("drop");
    tick();
    total++;
    if (cy !== 10'd216) $display("FAIL drop_cy got %0d expected 216", cy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    rx_data = "d";
    rx_valid = 1'b1;
    frame_tick = 1'b1;
    exp_q.push_back("d");
    @(negedge clk);
    rx_valid = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    total++;
    if (cx !== 10'd320 || pending !== 1'b1) $display("FAIL coincident got cx=%0d p=%b expected 320 1", cx, pending);
    else passed++;
    tick();
    total++;
    if (cx !== 10'd328 || pending !== 1'b0) $display("FAIL next_tick got cx=%0d p=%b expected 328 0", cx, pending);
    else passed++;
    drain("b2b");
    tx_ready = 1'b0;
    send("c", 0);
    send("d", 0);
    tick();
    total++;
    if (cx !== 10'd336 || cl !== 2'd1 || drop_cnt !== 8'd1 || tx_valid !== 1'b1)
      $display("FAIL pre_reset got cx=%0d cl=%0d d=%0d v=%b expected 336 1 1 1", cx, cl, drop_cnt, tx_valid);
    else passed++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({cx, cy, cl, tx_valid, tx_data, pending, drop_cnt} !==
        {10'd320, 10'd240, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0})
      $display("FAIL async_reset got cx=%0d cy=%0d cl=%0d v=%b d=%h p=%b dc=%0d expected 320 240 0 0 00 0 0",
               cx, cy, cl, tx_valid, tx_data, pending, drop_cnt);
    else passed++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_move();
    test_edges();
    test_colour();
    test_drop();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Command-decoding stage that sits between the UART receiver and `vga_test`. It turns received ASCII command bytes into the cursor position (`cX`, `cY`) and colour (`cl`) that `vga_test` draws. Position and colour changes go into shadow registers and reach the display outputs only on a frame tick, so the cursor never tears mid-frame. Each recognised byte is echoed back toward the UART transmitter through a one-entry valid/ready buffer.

## Interface
- `H_MAX`, 639: largest legal X coordinate.
- `V_MAX`, 479: largest legal Y coordinate.
- `STEP`, 8: pixels moved per lowercase move command. Uppercase moves by 4*STEP.
- `X_INIT`, 320: X coordinate after reset and after the `r` command.
- `Y_INIT`, 240: Y coordinate after reset and after the `r` command.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe, one per received byte.
- `frame_tick`  in  1  one-cycle strobe at vertical blanking; commits the shadow registers.
- `tx_ready`  in  1  UART transmitter can accept a byte.
- `tx_data`  out  8  echo byte.
- `tx_valid`  out  1  echo byte available.
- `cX`  out  10  committed cursor X.
- `cY`  out  10  committed cursor Y.
- `cl`  out  2  committed cursor colour.
- `pending`  out  1  shadow registers differ from the committed outputs.
- `drop_cnt`  out  8  number of echoes lost to a full buffer; saturates at 255.

## Operation
- Command decode (applied to the shadow registers `sx`, `sy`, `scl`):
  - `w` / `W`: Y − STEP / Y − 4·STEP.
  - `s` / `S`: Y + STEP / Y + 4·STEP.
  - `a` / `A`: X − STEP / X − 4·STEP.
  - `d` / `D`: X + STEP / X + 4·STEP.
  - `c`: `scl` ← `scl` + 1 mod 4.
  - `r`: `sx` ← X_INIT, `sy` ← Y_INIT; colour unchanged.
  - Any other byte: shadows unchanged.
- Arithmetic: computed in 12-bit signed, then clamped to [0, H_MAX] for X and [0, V_MAX] for Y. A move from 3 with STEP 8 gives 0. A move from 636 gives 639.
- Echo: a recognised byte is echoed unchanged. An unrecognised byte is echoed as 0x3F ('?').
- Echo buffer has two states:
  - EMPTY: `tx_valid` = 0. On `rx_valid`, load the byte and go to FULL.
  - FULL: `tx_valid` = 1 and `tx_data` held stable. On `tx_ready`, return to EMPTY.
  - FULL with `tx_ready` and `rx_valid` in the same cycle: load the new byte and stay FULL.
  - FULL with `rx_valid` and no `tx_ready`: the new byte's echo is dropped and `drop_cnt` increments. Its command still executes.
- Commit: on `frame_tick`, `cX`/`cY`/`cl` ← `sx`/`sy`/`scl`.
- `pending` = (`sx`,`sy`,`scl`) ≠ (`cX`,`cY`,`cl`), registered.

## Timing
- Reset values: `cX` = `sx` = X_INIT; `cY` = `sy` = Y_INIT; `cl` = `scl` = 0; `tx_valid` = 0; `tx_data` = 0; `pending` = 0; `drop_cnt` = 0.
- Reset takes effect immediately, including mid-echo; an in-flight `tx_valid` drops at once.
- `rx_valid` at edge n: the shadow update and `tx_valid` are visible after edge n.
- `pending` reflects the update after edge n+1.
- `frame_tick` at edge m: `cX`/`cY`/`cl` are updated after edge m.
- `rx_valid` and `frame_tick` in the same cycle: the commit takes the pre-update shadow. The new command reaches the outputs on the next `frame_tick`, and `pending` = 1 meanwhile.
- Several commands between ticks accumulate; only the final shadow value is committed.
- `frame_tick` with `pending` = 0 leaves the outputs unchanged.

## Configuration
- `CURSOR_WRAP_EN` defined: moves wrap modulo (H_MAX+1) for X and (V_MAX+1) for Y instead of clamping.
  - `a` from X = 3, STEP 8 → X = 635 (default H_MAX).
  - `s` from Y = 476 → Y = 4.
- `CURSOR_WRAP_EN` undefined: clamping as described in Operation.

## Test plan
- Reset, no stimulus → `cX`=320, `cY`=240, `cl`=0, `tx_valid`=0, `pending`=0.
- `d`, `d`, `S`, then `frame_tick` → `cX`=336, `cY`=272, `pending` 1→0, three echoes 0x64, 0x64, 0x53 with `tx_ready` held 1.
- 50× `a` with no tick, then `frame_tick` → `cX`=0 when clamping; with `CURSOR_WRAP_EN` defined, `cX`=560.
- `c` ×5 then `frame_tick` → `cl`=1; byte 0x7A → echo 0x3F, shadows unchanged.
- `tx_ready`=0, send `w`, `w`, `w` → `tx_data`=0x77 held, `drop_cnt`=2. Raise `tx_ready` → one echo, `tx_valid` falls; `sy`=216.
- `d` coincident with `frame_tick` → `cX` stays 320 and `pending`=1. Next tick → `cX`=328. Assert `reset` low mid-sequence → all outputs return to their reset values immediately.
